// File: rtl/act_sram_pkg.sv
// rtl/act_sram_pkg.sv - shared geometry, widths and error source encoding for the activation SRAM arbiter
package act_sram_pkg;

    localparam int CH_NUM       = 3;
    localparam int ACT_PER_ADDR = 9;
    localparam int BW_PER_ACT   = 10;
    localparam int DEPTH        = 480;
    localparam int AW           = 9;
    localparam int WM_W         = CH_NUM * ACT_PER_ADDR;
    localparam int DW           = WM_W * BW_PER_ACT;

    typedef enum logic [1:0] {
        SRC_LD = 2'd0,
        SRC_WB = 2'd1,
        SRC_RD = 2'd2
    } src_e;

    function automatic logic addr_oor(input logic [AW-1:0] addr);
        return addr >= AW'(DEPTH);
    endfunction

endpackage

// File: rtl/act_sram_arbiter_rr_arb2.sv
// rtl/act_sram_arbiter_rr_arb2.sv - two-input round-robin arbiter with combinational grants
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // ptr_q = 0 favours requester 0 when both ask
    logic ptr_q;
    logic ptr_d;

    assign gnt0_o = req0_i & (~req1_i | ~ptr_q);
    assign gnt1_o = req1_i & (~req0_i | ptr_q);
    assign ptr_d  = (req0_i & req1_i) ? ~ptr_q : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/act_sram_arbiter.sv
// rtl/act_sram_arbiter.sv - grants one write and one read per cycle onto the activation SRAM pins
module act_sram_arbiter
    import act_sram_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_req_i,
    output logic            ld_gnt_o,
    input  logic [AW-1:0]   ld_addr_i,
    input  logic [WM_W-1:0] ld_wen_i,
    input  logic [DW-1:0]   ld_wdata_i,
    input  logic            wb_req_i,
    output logic            wb_gnt_o,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [WM_W-1:0] wb_wen_i,
    input  logic [DW-1:0]   wb_wdata_i,
    input  logic            rd_req_i,
    output logic            rd_gnt_o,
    input  logic [AW-1:0]   rd_addr_i,
    output logic            rd_valid_o,
    output logic [DW-1:0]   rd_data_o,
    output logic            err_o,
    output logic [1:0]      err_src_o,
    output logic            sram_csb_o,
    output logic            sram_wsb_o,
    output logic [WM_W-1:0] sram_wordmask_o,
    output logic [DW-1:0]   sram_wdata_o,
    output logic [AW-1:0]   sram_waddr_o,
    output logic [AW-1:0]   sram_raddr_o,
    input  logic [DW-1:0]   sram_rdata_i
);

    logic            wr_go, wr_oor, wr_issue, rd_issue, raw_hit;
    logic            ld_oor, wb_oor, rd_oor;
    logic [AW-1:0]   wr_addr;
    logic [WM_W-1:0] wr_wen;
    logic [DW-1:0]   wr_wdata;

    logic            csb_q, csb_d, wsb_q, wsb_d, err_q, err_d;
    logic [WM_W-1:0] wordmask_q, wordmask_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
    logic [1:0]      rd_vld_q, rd_vld_d;
    src_e            err_src_q, err_src_d;

    rr_arb2 u_wr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0_i (ld_req_i),
        .req1_i (wb_req_i),
        .gnt0_o (ld_gnt_o),
        .gnt1_o (wb_gnt_o)
    );

    assign ld_oor   = addr_oor(ld_addr_i);
    assign wb_oor   = addr_oor(wb_addr_i);
    assign rd_oor   = addr_oor(rd_addr_i);

    assign wr_go    = ld_gnt_o | wb_gnt_o;
    assign wr_addr  = wb_gnt_o ? wb_addr_i  : ld_addr_i;
    assign wr_wen   = wb_gnt_o ? wb_wen_i   : ld_wen_i;
    assign wr_wdata = wb_gnt_o ? wb_wdata_i : ld_wdata_i;
    assign wr_oor   = wb_gnt_o ? wb_oor     : ld_oor;
    assign wr_issue = wr_go & ~wr_oor & (|wr_wen);

    // A same-address read waits one cycle so it is issued after the write commits
    assign raw_hit  = wr_go & (wr_addr == rd_addr_i);
    assign rd_gnt_o = rd_req_i & ~raw_hit;
    assign rd_issue = rd_gnt_o & ~rd_oor;

    always_comb begin
        csb_d      = ~(wr_issue | rd_issue);
        wsb_d      = ~wr_issue;
        wordmask_d = wr_issue ? ~wr_wen : '1;
        wdata_d    = wr_issue ? wr_wdata : wdata_q;
        waddr_d    = wr_issue ? wr_addr : waddr_q;
        raddr_d    = rd_issue ? rd_addr_i : raddr_q;
        rd_vld_d   = {rd_vld_q[0], rd_issue};
        err_d      = 1'b1;
        err_src_d  = err_src_q;
        if (ld_gnt_o && ld_oor) begin
            err_src_d = SRC_LD;
        end else if (wb_gnt_o && wb_oor) begin
            err_src_d = SRC_WB;
        end else if (rd_gnt_o && rd_oor) begin
            err_src_d = SRC_RD;
        end else begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_q      <= 1'b1;
            wsb_q      <= 1'b1;
            wordmask_q <= '1;
            wdata_q    <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            rd_vld_q   <= '0;
            err_q      <= 1'b0;
            err_src_q  <= SRC_LD;
        end else begin
            csb_q      <= csb_d;
            wsb_q      <= wsb_d;
            wordmask_q <= wordmask_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            rd_vld_q   <= rd_vld_d;
            err_q      <= err_d;
            err_src_q  <= err_src_d;
        end
    end

    assign sram_csb_o      = csb_q;
    assign sram_wsb_o      = wsb_q;
    assign sram_wordmask_o = wordmask_q;
    assign sram_wdata_o    = wdata_q;
    assign sram_waddr_o    = waddr_q;
    assign sram_raddr_o    = raddr_q;
    assign rd_valid_o      = rd_vld_q[1];
    assign rd_data_o       = sram_rdata_i;
    assign err_o           = err_q;
    assign err_src_o       = err_src_q;

endmodule

// File: doc/act_sram_arbiter.md
# act_sram_arbiter

Shares the 480×270-bit activation SRAM between three requesters: the input-image loader (write), the layer writeback path (write) and the convolution read engine (read). Each cycle it grants at most one write and one read, drives the SRAM control pins from registered outputs, and returns read data with a valid strobe. It sits directly in front of the activation SRAM instance. Loader and writeback therefore never touch the SRAM pins.

## Interface
- CH_NUM, 3, channels per SRAM word
- ACT_PER_ADDR, 9, activations per channel per word
- BW_PER_ACT, 10, bits per activation
- DEPTH, 480, SRAM word count
- AW, 9, address width
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- ld_req / wb_req  in  1  write request from loader / writeback
- ld_gnt / wb_gnt  out  1  write grant (combinational)
- ld_addr / wb_addr  in  AW  write address
- ld_wen / wb_wen  in  CH_NUM*ACT_PER_ADDR (27)  per-activation write enable, 1 = write
- ld_wdata / wb_wdata  in  270  write data
- rd_req  in  1  read request
- rd_gnt  out  1  read grant (combinational)
- rd_addr  in  AW  read address
- rd_valid  out  1  rd_data valid strobe
- rd_data  out  270  read data, pass-through of sram_rdata
- err  out  1  one-cycle pulse on a dropped out-of-range request
- err_src  out  2  source of the last error: 0 = LD, 1 = WB, 2 = RD
- sram_csb, sram_wsb  out  1  SRAM chip select / write select, active-low
- sram_wordmask  out  27  1 = keep old activation
- sram_wdata  out  270  SRAM write data
- sram_waddr, sram_raddr  out  AW  SRAM write / read address
- sram_rdata  in  270  SRAM read data

## Operation
- Handshake: a requester holds req and payload stable until it sees gnt high in the same cycle. A transfer occurs on the clk edge where req and gnt are both 1.
- Write arbitration is 2-way round robin.
  - If only one of ld_req and wb_req is high, that requester is granted.
  - If both are high, the requester not granted last is granted.
  - The pointer updates only on a contended grant. After reset it favours LD.
- Read arbitration: rd_gnt = rd_req, except in the RAW stall case below.
- RAW stall: if a write is granted this cycle and its address equals rd_addr, rd_gnt is 0 this cycle. The read is granted the next cycle and returns the new data.
- Out-of-range request (addr ≥ DEPTH):
  - The request is granted, so the requester cannot deadlock.
  - No SRAM access is issued for it.
  - err pulses in the next cycle and err_src is updated.
  - For an out-of-range read, rd_valid stays 0.
- Write with wen all-zero: granted, no SRAM write issued (sram_wsb stays 1).
- Issue stage, registered on the edge after a grant:
  - sram_csb = 0 if any valid access is issued, else 1.
  - sram_wsb = 0 only for a valid write.
  - sram_wordmask = ~wen.
  - sram_waddr, sram_wdata and sram_raddr hold their last value when not updated.
- A write-only issue also performs a dummy SRAM read. rd_valid is not asserted for it.

## Timing
- Read latency: grant in cycle N, SRAM pins driven in N+1, rd_valid = 1 and rd_data valid in N+2.
- Write commits to the SRAM at the end of cycle N+1.
- Throughput: one write plus one read per cycle. Back-to-back grants are allowed.
- Reset values:
  - sram_csb = 1, sram_wsb = 1, sram_wordmask = all 1s.
  - sram_wdata = 0, sram_waddr = 0, sram_raddr = 0.
  - rd_valid = 0, err = 0, err_src = 0, round-robin pointer = LD.
- Reset mid-operation: the issue stage and the rd_valid pipeline clear immediately. Any in-flight read never produces rd_valid.
- A write in cycle N+1 and a read granted in N+1 to the same address do not conflict; the read observes the write.

## Structure
- Package act_sram_pkg holds:
  - CH_NUM, ACT_PER_ADDR, BW_PER_ACT, DEPTH and AW.
  - Derived widths: WM_W = 27, DW = 270.
  - Source enum: SRC_LD = 0, SRC_WB = 1, SRC_RD = 2.
- Sub-module rr_arb2: 2-input round-robin arbiter with request inputs, combinational grant outputs and the registered pointer.
- The top level holds the RAW compare, range checks, issue registers and the 2-stage rd_valid shift register.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> all outputs take their reset values immediately and asynchronously; sram_csb = 1, sram_wordmask = 27'h7FFFFFF.
- Solo read: preload word 5, then rd_req with rd_addr = 5 in cycle 0 -> rd_gnt = 1 in cycle 0; sram_csb = 0 and sram_raddr = 5 in cycle 1; rd_valid = 1 in cycle 2 with rd_data = the preloaded word.
- Contention: ld_req and wb_req both high for 4 cycles -> grant sequence LD, WB, LD, WB; exactly one sram_wsb low per cycle.
- Partial write: ld_wen = 27'h1 with wdata = all 1s to address 3 (preloaded with 0) -> sram_wordmask = 27'h7FFFFFE; read back gives bits [9:0] = 10'h3FF and all other bits 0.
- RAW: wb write and read both to address 7 in cycle 0 -> rd_gnt = 0 in cycle 0, rd_gnt = 1 in cycle 1, rd_valid in cycle 3 with the new data.
- Out of range: ld_addr = 480 -> ld_gnt = 1, sram_wsb stays 1, err = 1 in cycle 1 with err_src = 0.
